// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display blocks.
// Segment patterns are ordered a..g with a in bit 6 and g in bit 0.
package seg7_pkg;

    localparam logic [6:0] SEG_0      = 7'b1111110;
    localparam logic [6:0] SEG_1      = 7'b0110000;
    localparam logic [6:0] SEG_2      = 7'b1101101;
    localparam logic [6:0] SEG_3      = 7'b1111001;
    localparam logic [6:0] SEG_4      = 7'b0110011;
    localparam logic [6:0] SEG_5      = 7'b1011011;
    localparam logic [6:0] SEG_6      = 7'b1011111;
    localparam logic [6:0] SEG_7      = 7'b1110000;
    localparam logic [6:0] SEG_8      = 7'b1111111;
    localparam logic [6:0] SEG_9      = 7'b1111011;
    localparam logic [6:0] SEG_A      = 7'b1110111;
    localparam logic [6:0] SEG_B      = 7'b0011111;
    localparam logic [6:0] SEG_C      = 7'b1001110;
    localparam logic [6:0] SEG_D      = 7'b0111101;
    localparam logic [6:0] SEG_E      = 7'b1001111;
    localparam logic [6:0] SEG_F      = 7'b1000111;
    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam logic [6:0] SEG_ALL_ON = 7'b1111111;

    localparam int SEG7_DIGITS_MAX = 8;

    // Digit index width: $clog2(digits), never narrower than one bit.
    function automatic int seg7_idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    localparam int SEG7_IDX_W_MAX = seg7_idx_w(SEG7_DIGITS_MAX);

    // Nibble to segment pattern; codes 10..15 go dark unless hex display is enabled.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble, input logic hex_en);
        logic [6:0] pat;
        case (nibble)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = hex_en ? SEG_A : SEG_BLANK;
            4'hB: pat = hex_en ? SEG_B : SEG_BLANK;
            4'hC: pat = hex_en ? SEG_C : SEG_BLANK;
            4'hD: pat = hex_en ? SEG_D : SEG_BLANK;
            4'hE: pat = hex_en ? SEG_E : SEG_BLANK;
            default: pat = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between a datapath block (master) and the display scanner (slave).
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    // Handshake: there is no ready. load is a one-cycle capture strobe; on every
    // clock edge where load=1, data_in and dp_in are taken as the new display
    // value. lamp_test_n, blank_n and lz_en are levels sampled every cycle.
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                lamp_test_n;
    logic                blank_n;
    logic                lz_en;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    modport master (
        output data_in, dp_in, load, lamp_test_n, blank_n, lz_en,
        input  seg, dp, an
    );

    modport slave (
        input  data_in, dp_in, load, lamp_test_n, blank_n, lz_en,
        output seg, dp, an
    );
endinterface

// File: rtl/seg7_scan_driver_prescaler.sv
// Free-running modulo-DIV counter. Exposes the value the counter takes on the
// next edge plus a strobe marking the final count of each period, so callers
// can register outputs that line up with the counter itself.
module seg7_prescaler #(
    parameter int DIV = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt_next,
    output logic         tc
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: wrap to zero after DIV-1.
    always_comb begin
        tc    = (cnt_q == W'(DIV - 1));
        cnt_d = tc ? '0 : cnt_q + W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_next = cnt_d;
endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment scanner: load-enabled value register, registered
// controls, digit scan with guard time, leading-zero suppression and pin
// polarity. Output registers are computed from the next prescaler/index
// values so seg/dp/an always match the slot the counters are in.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYC      = 2,
    parameter bit HEX_EN         = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int IDX_W = seg7_idx_w(DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    logic [PRE_W-1:0]    pre_d;
    logic                pre_tc;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic                lamp_q, lamp_d, blank_q, blank_d, lz_q, lz_d;
    logic [6:0]          seg_q, seg_d;
    logic                dpo_q, dpo_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [DIGITS-1:0]   lz_mask;
    logic [DIGITS-1:0]   an_scan;
    logic                zero_run;
    logic                in_guard;

    seg7_prescaler #(.DIV(REFRESH_DIV), .W(PRE_W)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .cnt_next (pre_d),
        .tc       (pre_tc)
    );

    // Digit index advances at the end of each slot; value register loads on strobe.
    always_comb begin
        idx_d = idx_q;
        if (pre_tc) begin
            if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
            else                             idx_d = idx_q + IDX_W'(1);
        end
        data_d  = bus.load ? bus.data_in : data_q;
        dp_d    = bus.load ? bus.dp_in   : dp_q;
        lamp_d  = bus.lamp_test_n;
        blank_d = bus.blank_n;
        lz_d    = bus.lz_en;
    end

    // Index, value and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            lamp_q  <= 1'b1;
            blank_q <= 1'b1;
            lz_q    <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            data_q  <= data_d;
            dp_q    <= dp_d;
            lamp_q  <= lamp_d;
            blank_q <= blank_d;
            lz_q    <= lz_d;
        end
    end

    // Output selection: blank beats lamp test beats normal decode.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (data_q[4*k +: 4] == 4'd0);
            if (k != 0) lz_mask[k] = lz_q & zero_run;
        end

        an_scan        = '0;
        an_scan[idx_d] = 1'b1;
        in_guard       = (int'(pre_d) < GUARD_CYC);

        seg_d = lz_mask[idx_d] ? SEG_BLANK : seg7_decode(data_q[4*idx_d +: 4], HEX_EN);
        dpo_d = dp_q[idx_d];
        an_d  = in_guard ? '0 : an_scan;

        if (!lamp_q) begin
            seg_d = SEG_ALL_ON;
            dpo_d = 1'b1;
        end
        if (!blank_q) begin
            seg_d = SEG_BLANK;
            dpo_d = 1'b0;
            an_d  = '0;
        end
    end

    // Registered logical outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            dpo_q <= 1'b0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_d;
            dpo_q <= dpo_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg = seg_q ^ {7{SEG_ACTIVE_LOW}};
    assign bus.dp  = dpo_q ^ SEG_ACTIVE_LOW;
    assign bus.an  = an_q ^ {DIGITS{AN_ACTIVE_LOW}};
endmodule
